truth_table_sweeper: RTL
========================

# truth_table_sweeper

Parametrised truth-table sweep engine for N-input, single-output logic circuits. It drives every input combination onto an external combinational netlist, such as a NOR/NOT gate circuit for a hex-coded function like 0xB6. After a programmable settle time it samples the netlist's response and assembles the observed truth table. It then compares that table against a target table and reports the mismatch mask, the mismatch count and a pass flag. It sits between the circuit-under-test wrapper and the score-calculation logic.

## Interface
Parameters:
- N_IN, 3, number of circuit inputs (1..8); the table width is T = 2^N_IN.
- SETTLE, 2, extra hold cycles per vector before sampling (0..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high; clears all state and outputs.
- start  input  1  single-cycle request; accepted only while busy=0.
- target  input  T  expected truth table; bit k is the output for input index k; captured when start is accepted.
- vec_out  output  N_IN  input vector driven to the circuit; bit j is input j of index k.
- dut_out  input  1  circuit output, sampled synchronously.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when results become valid.
- observed  output  T  assembled observed truth table.
- mismatch_mask  output  T  observed XOR captured target.
- mismatch_cnt  output  N_IN+1  popcount of mismatch_mask.
- pass  output  1  mismatch_cnt == 0, qualified by a completed sweep.

## Operation
- FSM states are IDLE, SWEEP and FINISH.
- IDLE:
  - start=1 captures target into an internal register.
  - Clears observed, mismatch_mask, mismatch_cnt and pass.
  - Sets vec_out=0, loads the settle counter with SETTLE, sets busy=1 and moves to SWEEP.
- SWEEP, each cycle:
  - If the settle counter is nonzero, decrement it.
  - Otherwise write observed[vec_out] <= dut_out.
  - If vec_out == T-1, go to FINISH.
  - Else increment vec_out and reload the counter with SETTLE.
- FINISH, one cycle:
  - Register mismatch_mask = observed ^ captured target and mismatch_cnt = popcount of that mask.
  - Set pass = (popcount == 0).
  - Set done=1 for this cycle only, busy=0, vec_out=0, then return to IDLE.
- Each vector is held for exactly SETTLE+1 cycles. With SETTLE=0, one vector is sampled per cycle.
- Results (observed, mask, cnt, pass) hold their values until the next accepted start or reset.
- start while busy=1 is ignored and has no side effects.
- Changes to target after capture have no effect on the running sweep.
- vec_out never exceeds T-1; the index does not wrap around during a sweep.
- Reset mid-sweep aborts immediately, discards all partial results and returns to IDLE. No done pulse is issued.
- Reset values: vec_out=0, busy=0, done=0, observed=0, mismatch_mask=0, mismatch_cnt=0, pass=0.

## Timing
- Take start as sampled high at edge E0.
- Edge E0:
  - busy=1 and vec_out=0 from this edge.
- Vector k:
  - Driven from edge E0 + k·(SETTLE+1).
  - Sampled at edge E0 + (k+1)·(SETTLE+1).
- Edge E0 + T·(SETTLE+1), the last sample edge:
  - The FSM enters FINISH.
  - busy stays 1 until the next edge.
- Edge E0 + T·(SETTLE+1) + 1:
  - done=1 and results are valid.
  - busy=0; the FSM is back in IDLE.
- Total latency from start to done is T·(SETTLE+1) + 1 cycles.
  - N_IN=3, SETTLE=2: 25 cycles.
- A start asserted in the cycle where done is high is accepted, giving back-to-back sweeps.
- dut_out must be stable within SETTLE+1 cycles of a vec_out change.

## Test plan
- Target 0xB6 with a golden lookup circuit, N_IN=3, SETTLE=2 -> done exactly 25 cycles after start; observed=0xB6, mismatch_mask=0x00, mismatch_cnt=0, pass=1.
- Target 0xB6 with a circuit whose index 5 is inverted -> observed=0x96, mismatch_mask=0x20, mismatch_cnt=1, pass=0.
- Target 0xB6 with dut_out stuck at 0 -> observed=0x00, mismatch_mask=0xB6, mismatch_cnt=5, pass=0.
- During a sweep, pulse start again and change target to 0xFF -> no restart, results still computed against 0xB6; vec_out sequence is 0..7, each vector held 3 cycles.
- Assert rst while vec_out=3 -> all outputs 0 immediately, no done pulse; the next start runs a full 25-cycle sweep from vector 0.
- N_IN=4, SETTLE=0, target 0x6996 with a 4-input XOR circuit -> done 17 cycles after start, pass=1. A start in the done cycle is accepted and a second done follows 17 cycles later.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between the sweep engine, its controller and the
// circuit under test.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    localparam int T = 1 << N_IN;

    logic            start;
    logic [T-1:0]    target;
    logic [N_IN-1:0] vec_out;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic [T-1:0]    observed;
    logic [T-1:0]    mismatch_mask;
    logic [N_IN:0]   mismatch_cnt;
    logic            pass;

    modport master (
        output start, target, dut_out,
        input  vec_out, busy, done, observed, mismatch_mask, mismatch_cnt, pass
    );

    modport slave (
        input  start, target, dut_out,
        output vec_out, busy, done, observed, mismatch_mask, mismatch_cnt, pass
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input combination of an external N_IN-input circuit, samples its
// response after a settle delay and scores the observed table against a target.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);
    localparam int T = 1 << N_IN;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SWEEP  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [7:0]      SETTLE_V = 8'(SETTLE);
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

    function automatic logic [N_IN:0] popcount(input logic [T-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int i = 0; i < T; i++) begin
            c = c + {{N_IN{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [T-1:0]    tgt_q, tgt_d;
    logic [T-1:0]    obs_q, obs_d;
    logic [T-1:0]    mask_q, mask_d;
    logic [N_IN:0]   mcnt_q, mcnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic [T-1:0]    diff_s;
    logic [N_IN:0]   diff_cnt_s;

    assign diff_s     = obs_q ^ tgt_q;
    assign diff_cnt_s = popcount(diff_s);

    // Next-state logic for the IDLE / SWEEP / FINISH sequencer and its datapath.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        obs_d   = obs_q;
        mask_d  = mask_q;
        mcnt_d  = mcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tgt_d   = bus.target;
                    obs_d   = '0;
                    mask_d  = '0;
                    mcnt_d  = '0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = SETTLE_V;
                    busy_d  = 1'b1;
                    state_d = S_SWEEP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SWEEP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    obs_d[vec_q] = bus.dut_out;
                    // The last index finishes in place so vec_out never wraps.
                    if (vec_q == VEC_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                        cnt_d = SETTLE_V;
                    end
                end
            end
            S_FINISH: begin
                mask_d  = diff_s;
                mcnt_d  = diff_cnt_s;
                pass_d  = (diff_cnt_s == '0);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                vec_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                vec_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any sweep without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= 8'd0;
            tgt_q   <= '0;
            obs_q   <= '0;
            mask_q  <= '0;
            mcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            obs_q   <= obs_d;
            mask_q  <= mask_d;
            mcnt_q  <= mcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.vec_out       = vec_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.observed      = obs_q;
    assign bus.mismatch_mask = mask_q;
    assign bus.mismatch_cnt  = mcnt_q;
    assign bus.pass          = pass_q;
endmodule
